// File: rtl/alufpu_div.sv
// Iterative restoring divider (signed/unsigned); one quotient bit per cycle.
// Latency WIDTH+1 cycles from start, 1 cycle for divide-by-zero (and early-out when ALUFPU_DIV_EARLY_OUT_EN is defined).
// Backpressure: start is only accepted in IDLE; busy stalls the operand path, start while busy is dropped.
module alufpu_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [0:WIDTH-1] busA,
    input  logic [0:WIDTH-1] busB,
    output logic             busy,
    output logic             done,
    output logic [0:WIDTH-1] quotient,
    output logic [0:WIDTH-1] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] part;     // partial remainder magnitude
    logic [WIDTH-1:0] dvd;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs;      // divisor magnitude
    logic             q_neg;
    logic             r_neg;
    logic             dbz;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH:0]   trial_base;
    logic [WIDTH:0]   trial_diff;
    logic             trial_ok;

    // Operand magnitudes and the trial subtraction of the current step.
    always_comb begin
        op_a       = busA;
        op_b       = busB;
        sign_a     = is_signed & op_a[WIDTH-1];
        sign_b     = is_signed & op_b[WIDTH-1];
        mag_a      = sign_a ? -op_a : op_a;
        mag_b      = sign_b ? -op_b : op_b;
        trial_base = {part, dvd[WIDTH-1]};
        trial_diff = trial_base - {1'b0, dvs};
        // Sign bit of the (WIDTH+1)-bit difference is set only when the divisor did not fit.
        trial_ok   = ~trial_diff[WIDTH];
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            part        <= '0;
            dvd         <= '0;
            dvs         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dbz         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvs         <= mag_b;
                        q_neg       <= sign_a ^ sign_b;
                        r_neg       <= sign_a;
                        count       <= '0;
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        if (mag_b == '0) begin
                            // Parking |A| in the remainder lets FIX's sign fix rebuild busA exactly.
                            dbz   <= 1'b1;
                            part  <= mag_a;
                            dvd   <= '0;
                            state <= FIX;
`ifdef ALUFPU_DIV_EARLY_OUT_EN
                        end else if (mag_b > mag_a) begin
                            dbz   <= 1'b0;
                            part  <= mag_a;
                            dvd   <= '0;
                            state <= FIX;
`endif
                        end else begin
                            dbz   <= 1'b0;
                            part  <= '0;
                            dvd   <= mag_a;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    part  <= trial_ok ? trial_diff[WIDTH-1:0] : trial_base[WIDTH-1:0];
                    dvd   <= {dvd[WIDTH-2:0], trial_ok};
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient    <= dbz ? '1 : (q_neg ? -dvd : dvd);
                    remainder   <= r_neg ? -part : part;
                    div_by_zero <= dbz;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
